// File: rtl/us_delay_pkg.sv
// Shared types, defaults and round-robin helper for the microsecond delay arbiter.
package us_delay_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int CLK_DIV_DEFAULT = 100;
   localparam int DLY_W_DEFAULT   = 16;
   localparam int MAX_NREQ        = 8;

   // Returns {found, index} of the first set request at or after ptr, wrapping modulo nreq.
   function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input logic [2:0] ptr,
                                          input int nreq);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      // Walk backwards so the earliest candidate in search order is written last.
      for (int k = MAX_NREQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if (req[idx]) begin
               res = {1'b1, idx};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/us_delay_arbiter_tick_gen.sv
// Modulo-CLK_DIV prescaler with a registered one-cycle tick and synchronous clear.
module tick_gen
   import us_delay_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int DIV_W   = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
   // A clear loads 1, so the registered tick lands on the last cycle of each
   // CLK_DIV-long period measured from the clearing edge.
   localparam logic [DIV_W-1:0] CLR_VAL = DIV_W'((CLK_DIV > 1) ? 1 : 0);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = CLR_VAL;
      end else begin
         tick_d = (cnt_q == LAST);
         cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/us_delay_arbiter.sv
// Round-robin arbiter sharing one microsecond delay timer between NREQ requesters.
// Optional macro US_DLY_ABORT_EN: dropping req of the granted requester aborts its delay.
module us_delay_arbiter
   import us_delay_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int DIV_W   = 7,
   parameter int DLY_W   = DLY_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DLY_W-1:0] dly_us,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic                  tick_1us
);

   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   state_e           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             busy_q, busy_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [DLY_W-1:0] rem_q, rem_d;

   logic [MAX_NREQ-1:0] req_ext;
   logic [DLY_W-1:0]    dly_arr [NREQ];
   logic [DLY_W-1:0]    dly_sel;
   logic [3:0]          pick;
   logic [2:0]          next_ptr;
   logic                dly_clr;
   logic                dly_tick;
   logic                abort_hit;

   tick_gen #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_free_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .tick  (tick_1us)
   );

   tick_gen #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_dly_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (dly_clr),
      .tick  (dly_tick)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_dly
      assign dly_arr[gi] = dly_us[gi*DLY_W +: DLY_W];
   end

   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
   end

   assign pick     = rr_pick(req_ext, rr_ptr_q, NREQ);
   assign next_ptr = (sel_q == 3'(NREQ - 1)) ? 3'd0 : sel_q + 3'd1;

   always_comb begin
      dly_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[2:0] == 3'(i)) dly_sel = dly_arr[i];
      end
   end

`ifdef US_DLY_ABORT_EN
   always_comb begin
      abort_hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_q == 3'(i)) abort_hit = !req[i];
      end
   end
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      busy_d   = busy_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      rem_d    = rem_q;
      dly_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick[3]) begin
               state_d = RUN;
               gnt_d   = ONE << pick[2:0];
               busy_d  = 1'b1;
               sel_d   = pick[2:0];
               rem_d   = dly_sel;
               dly_clr = 1'b1;
            end
         end
         RUN: begin
            if (abort_hit) begin
               state_d  = IDLE;
               gnt_d    = '0;
               busy_d   = 1'b0;
               rr_ptr_d = next_ptr;
            // A zero delay finishes one clock after the grant.
            end else if (rem_q == '0 || (dly_tick && rem_q == DLY_W'(1))) begin
               state_d = DONE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = ONE << sel_q;
            end else if (dly_tick) begin
               rem_d = rem_q - 1'b1;
            end
         end
         DONE: begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
         rem_q    <= rem_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_us_delay_arbiter.sv
// Randomized and directed bench for us_delay_arbiter against an event-time reference model.
module tb_us_delay_arbiter;

   localparam int NREQ    = 4;
   localparam int CLK_DIV = 100;
   localparam int DLY_W   = 16;
`ifdef US_DLY_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*DLY_W-1:0] dly_us = '0;
   logic [NREQ-1:0]       gnt, done;
   logic                  busy, tick_1us;

   us_delay_arbiter #(.NREQ(NREQ), .CLK_DIV(CLK_DIV), .DIV_W(7), .DLY_W(DLY_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .dly_us   (dly_us),
      .gnt      (gnt),
      .done     (done),
      .busy     (busy),
      .tick_1us (tick_1us)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cycle index since reset release, current owner, finishing edge,
   // earliest edge a new grant may happen, round-robin pointer.
   int k, m_cur, m_end, m_next, m_ptr, m_done_total;
   int gnt_cnt [NREQ];
   int done_log [$];
   bit rand_on = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_dly(input int i, input int v);
      dly_us[i*DLY_W +: DLY_W] = DLY_W'(v);
   endtask

   task automatic clear_logs();
      for (int i = 0; i < NREQ; i++) gnt_cnt[i] = 0;
      done_log.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      req   = '0;
      #1;
      check_eq("rst_async", 32'({gnt, done, busy, tick_1us}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_hold", 32'({gnt, done, busy, tick_1us}), 32'd0);
      reset  = 1'b1;
      k      = 0;
      m_cur  = -1;
      m_ptr  = 0;
      m_next = 1;
      clear_logs();
   endtask

   task automatic step();
      logic [NREQ-1:0] e_gnt, e_done;
      logic            e_busy, e_tick;
      int              d, sel;
      @(posedge clk);
      k++;
      e_done = '0;
      if (m_cur >= 0) begin
         if (ABORT_EN && !req[m_cur]) begin
            m_ptr  = (m_cur + 1) % NREQ;
            m_cur  = -1;
            m_next = k + 1;
         end else if (k == m_end) begin
            e_done[m_cur] = 1'b1;
            m_done_total++;
            m_ptr  = (m_cur + 1) % NREQ;
            m_cur  = -1;
            m_next = k + 2;
         end
      end else if (k >= m_next && req != '0) begin
         sel = -1;
         for (int j = 0; j < NREQ; j++) begin
            if (sel < 0 && req[(m_ptr + j) % NREQ]) sel = (m_ptr + j) % NREQ;
         end
         d     = int'(dly_us[sel*DLY_W +: DLY_W]);
         m_cur = sel;
         m_end = k + ((d == 0) ? 1 : d * CLK_DIV);
      end
      e_gnt  = (m_cur >= 0) ? (NREQ'(1) << m_cur) : '0;
      e_busy = (m_cur >= 0);
      e_tick = (k % CLK_DIV == 0);
      #1;
      check_eq($sformatf("outs@%0d", k), 32'({gnt, done, busy, tick_1us}),
               32'({e_gnt, e_done, e_busy, e_tick}));
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) gnt_cnt[i]++;
         if (done[i]) begin
            done_log.push_back(i);
            $display("cycle %0d: done[%0d]", k, i);
         end
         if (e_done[i]) req[i] = 1'b0;
      end
      if (rand_on) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b1;
            set_dly(i, int'($urandom_range(0, 3)));
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      m_done_total = 0;
      // Idle: free tick only.
      apply_reset();
      run(1000);
      check_eq("t1_nodone", 32'(done_log.size()), 32'd0);

      // Single 5 us delay.
      clear_logs();
      set_dly(1, 5);
      req[1] = 1'b1;
      run(505);
      check_eq("t2_gnt_len", 32'(gnt_cnt[1]), 32'd500);
      check_eq("t2_ndone", 32'(done_log.size()), 32'd1);
      if (done_log.size() == 1) check_eq("t2_who", 32'(done_log[0]), 32'd1);

      // Four simultaneous 2 us requests from pointer 0.
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_dly(i, 2);
      req = '1;
      run(820);
      check_eq("t3_ndone", 32'(done_log.size()), 32'd4);
      for (int i = 0; i < NREQ; i++) begin
         if (done_log.size() == 4) check_eq($sformatf("t3_order%0d", i), 32'(done_log[i]), 32'(i));
         check_eq($sformatf("t3_len%0d", i), 32'(gnt_cnt[i]), 32'd200);
      end

      // Pointer back at 0: requesters 0 and 3 both pending, 0 wins.
      clear_logs();
      for (int i = 0; i < NREQ; i++) set_dly(i, 0);
      req = 4'b1001;
      run(10);
      check_eq("t3_ptr_ndone", 32'(done_log.size()), 32'd2);
      if (done_log.size() == 2) check_eq("t3_ptr_first", 32'(done_log[0]), 32'd0);

      // Zero delay: one-cycle grant.
      clear_logs();
      req[2] = 1'b1;
      run(5);
      check_eq("t4_gnt_len", 32'(gnt_cnt[2]), 32'd1);
      check_eq("t4_ndone", 32'(done_log.size()), 32'd1);

      // Request dropped 150 cycles into a 10 us delay; later dly change must be ignored.
      clear_logs();
      set_dly(3, 10);
      req[3] = 1'b1;
      run(150);
      req[3] = 1'b0;
      set_dly(3, 7);
      run(900);
      check_eq("t5_gnt_len", 32'(gnt_cnt[3]), ABORT_EN ? 32'd150 : 32'd1000);
      check_eq("t5_ndone", 32'(done_log.size()), ABORT_EN ? 32'd0 : 32'd1);

      // Reset in the middle of an 8 us delay.
      apply_reset();
      set_dly(0, 8);
      req[0] = 1'b1;
      run(300);
      apply_reset();
      run(50);
      check_eq("t6_nodone", 32'(done_log.size()), 32'd0);
      check_eq("t6_nognt", 32'(gnt_cnt[0]), 32'd0);
      set_dly(0, 1);
      req[0] = 1'b1;
      run(110);
      check_eq("t6_regnt_len", 32'(gnt_cnt[0]), 32'd100);
      check_eq("t6_regnt_done", 32'(done_log.size()), 32'd1);

      // Random traffic, then drain all pending requests.
      clear_logs();
      m_done_total = 0;
      rand_on = 1'b1;
      run(3000);
      rand_on = 1'b0;
      run(1300);
      check_eq("t7_drained", 32'(req), 32'd0);
      check_eq("t7_ndone", 32'(done_log.size()), 32'(m_done_total));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
